alu_issue_stage: RTL and testbench

//   Decode-to-execute pipeline register that feeds ALU_v1. Captures decoded RV32I fields and

---
 rtl/alu_issue_stage.sv | 179 +++++++++++++++++
 tb/tb_alu_issue_stage.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_stage
// Purpose  : Decode-to-execute slot for ALU_v1. It forwards EX/WB results,
//            selects the operands and maps RV32I fields to an ALU op_code.
// Revision : 1.0  initial release
// ============================================================================
module alu_issue_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_opcode,
  input  logic [2:0]       in_funct3,
  input  logic             in_funct7_b5,
  input  logic [4:0]       in_rs1_addr,
  input  logic [4:0]       in_rs2_addr,
  input  logic [XLEN-1:0]  in_rs1_data,
  input  logic [XLEN-1:0]  in_rs2_data,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [4:0]       in_rd_addr,
  input  logic             fwd_ex_we,
  input  logic [4:0]       fwd_ex_rd,
  input  logic [XLEN-1:0]  fwd_ex_data,
  input  logic             fwd_wb_we,
  input  logic [4:0]       fwd_wb_rd,
  input  logic [XLEN-1:0]  fwd_wb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  alu_a,
  output logic [XLEN-1:0]  alu_b,
  output logic [3:0]       alu_op_code,
  output logic [4:0]       out_rd_addr,
  output logic             out_illegal,
  output logic [CNT_W-1:0] issue_count
);

  localparam logic [3:0] c_OP_ADD  = 4'd0;
  localparam logic [3:0] c_OP_SUB  = 4'd1;
  localparam logic [3:0] c_OP_AND  = 4'd2;
  localparam logic [3:0] c_OP_OR   = 4'd3;
  localparam logic [3:0] c_OP_XOR  = 4'd4;
  localparam logic [3:0] c_OP_SLL  = 4'd5;
  localparam logic [3:0] c_OP_SRL  = 4'd6;
  localparam logic [3:0] c_OP_SRA  = 4'd7;
  localparam logic [3:0] c_OP_SLT  = 4'd8;
  localparam logic [3:0] c_OP_SLTU = 4'd9;
  localparam logic [3:0] c_OP_ILL  = 4'hF;

  localparam logic [6:0] c_OPC_R     = 7'b0110011;
  localparam logic [6:0] c_OPC_I     = 7'b0010011;
  localparam logic [6:0] c_OPC_LUI   = 7'b0110111;
  localparam logic [6:0] c_OPC_AUIPC = 7'b0010111;

  logic             r_valid;
  logic [XLEN-1:0]  r_a;
  logic [XLEN-1:0]  r_b;
  logic [3:0]       r_op;
  logic [4:0]       r_rd;
  logic             r_ill;
  logic [CNT_W-1:0] r_count;

  logic             w_capture;
  logic [XLEN-1:0]  w_rs1;
  logic [XLEN-1:0]  w_rs2;
  logic [XLEN-1:0]  w_a;
  logic [XLEN-1:0]  w_b;
  logic [3:0]       w_op;
  logic             w_ill;

  // EX beats WB; x0 is hardwired zero in the register file, so never forwarded.
  function automatic logic [XLEN-1:0] f_fwd(input logic [4:0] rs, input logic [XLEN-1:0] rf);
    if (fwd_ex_we && (fwd_ex_rd == rs) && (rs != 5'd0))
      return fwd_ex_data;
    else if (fwd_wb_we && (fwd_wb_rd == rs) && (rs != 5'd0))
      return fwd_wb_data;
    else
      return rf;
  endfunction

  function automatic logic [3:0] f_alu_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? c_OP_SUB : c_OP_ADD;
      3'b001:  return c_OP_SLL;
      3'b010:  return c_OP_SLT;
      3'b011:  return c_OP_SLTU;
      3'b100:  return c_OP_XOR;
      3'b101:  return alt ? c_OP_SRA : c_OP_SRL;
      3'b110:  return c_OP_OR;
      default: return c_OP_AND;
    endcase
  endfunction

  assign in_ready  = !r_valid || out_ready;
  assign w_capture = in_valid && in_ready && !flush;
  assign w_rs1     = f_fwd(in_rs1_addr, in_rs1_data);
  assign w_rs2     = f_fwd(in_rs2_addr, in_rs2_data);

  always_comb begin
    w_a   = '0;
    w_b   = '0;
    w_op  = c_OP_ILL;
    w_ill = 1'b0;
    case (in_opcode)
      c_OPC_R: begin
        w_a  = w_rs1;
        w_b  = w_rs2;
        w_op = f_alu_op(in_funct3, in_funct7_b5);
        if (in_funct7_b5 && (in_funct3 != 3'b000) && (in_funct3 != 3'b101))
          w_ill = 1'b1;
      end
      c_OPC_I: begin
        w_a = w_rs1;
        // Only SRAI uses instr[30] as an op selector; elsewhere it is an immediate bit.
        w_op = f_alu_op(in_funct3, in_funct7_b5 && (in_funct3 == 3'b101));
        if ((in_funct3 == 3'b001) || (in_funct3 == 3'b101))
          w_b = {{(XLEN-5){1'b0}}, in_imm[4:0]};
        else
          w_b = in_imm;
        if ((in_funct3 == 3'b001) && in_funct7_b5)
          w_ill = 1'b1;
      end
      c_OPC_LUI: begin
        w_b  = in_imm;
        w_op = c_OP_ADD;
      end
      c_OPC_AUIPC: begin
        w_a  = in_pc;
        w_b  = in_imm;
        w_op = c_OP_ADD;
      end
      default: w_ill = 1'b1;
    endcase
    if (w_ill) begin
      w_a  = '0;
      w_b  = '0;
      w_op = c_OP_ILL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= c_OP_ILL;
      r_rd    <= '0;
      r_ill   <= 1'b0;
      r_count <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_capture) begin
      r_valid <= 1'b1;
      r_a     <= w_a;
      r_b     <= w_b;
      r_op    <= w_op;
      r_rd    <= in_rd_addr;
      r_ill   <= w_ill;
      r_count <= r_count + 1'b1;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid   = r_valid;
  assign alu_a       = r_a;
  assign alu_b       = r_b;
  assign alu_op_code = r_op;
  assign out_rd_addr = r_rd;
  assign out_illegal = r_ill;
  assign issue_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue_stage
// Purpose  : Scoreboard bench for alu_issue_stage, directed cases then random.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, in_valid, in_ready, in_funct7_b5;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr, fwd_ex_rd, fwd_wb_rd, out_rd_addr;
  logic [31:0] in_rs1_data, in_rs2_data, in_imm, in_pc, fwd_ex_data, fwd_wb_data;
  logic        fwd_ex_we, fwd_wb_we, out_valid, out_ready, out_illegal;
  logic [31:0] alu_a, alu_b, issue_count;
  logic [3:0]  alu_op_code;

  alu_issue_stage #(.XLEN(32), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7_b5(in_funct7_b5),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_imm(in_imm), .in_pc(in_pc), .in_rd_addr(in_rd_addr),
    .fwd_ex_we(fwd_ex_we), .fwd_ex_rd(fwd_ex_rd), .fwd_ex_data(fwd_ex_data),
    .fwd_wb_we(fwd_wb_we), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op_code(alu_op_code),
    .out_rd_addr(out_rd_addr), .out_illegal(out_illegal), .issue_count(issue_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic        ill;
    logic [4:0]  rd;
  } exp_t;

  exp_t        q[$];
  int          checks   = 0;
  int          failures = 0;
  bit          mon_en   = 1'b0;
  bit          m_valid  = 1'b0;
  logic [31:0] m_count  = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_src(input logic [4:0] rs, input logic [31:0] rf);
    if (rs == 0) return rf;
    if (fwd_ex_we && fwd_ex_rd == rs) return fwd_ex_data;
    if (fwd_wb_we && fwd_wb_rd == rs) return fwd_wb_data;
    return rf;
  endfunction

  // funct3 -> base op; the "alternate" form (SUB, SRA) is always base+1.
  function automatic exp_t ref_model();
    exp_t        e;
    logic [3:0]  tab [0:7];
    logic [31:0] s1, s2;
    tab = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};
    s1 = ref_src(in_rs1_addr, in_rs1_data);
    s2 = ref_src(in_rs2_addr, in_rs2_data);
    e.rd = in_rd_addr; e.ill = 1'b0; e.a = '0; e.b = '0; e.op = 4'hF;
    case (in_opcode)
      7'b0110011: begin
        e.a = s1; e.b = s2;
        if (in_funct7_b5 && !(in_funct3 == 0 || in_funct3 == 5)) e.ill = 1'b1;
        else e.op = tab[in_funct3] + {3'b0, in_funct7_b5};
      end
      7'b0010011: begin
        e.a = s1;
        if (in_funct3 == 1 && in_funct7_b5) e.ill = 1'b1;
        else if (in_funct3 == 1 || in_funct3 == 5) begin
          e.b  = in_imm & 32'h1F;
          e.op = tab[in_funct3] + {3'b0, (in_funct3 == 5) && in_funct7_b5};
        end else begin
          e.b = in_imm; e.op = tab[in_funct3];
        end
      end
      7'b0110111: begin e.b = in_imm; e.op = 4'd0; end
      7'b0010111: begin e.a = in_pc; e.b = in_imm; e.op = 4'd0; end
      default: e.ill = 1'b1;
    endcase
    if (e.ill) begin e.a = '0; e.b = '0; e.op = 4'hF; end
    return e;
  endfunction

  // Advance one edge, updating the bench's own view of the slot from what it drove.
  task automatic step();
    bit cap;
    @(posedge clk);
    cap = in_valid && (!m_valid || out_ready) && !flush;
    if (flush) m_valid = 1'b0;
    else if (cap) begin
      q.push_back(ref_model());
      m_valid = 1'b1;
      m_count = m_count + 1;
    end else if (out_ready) m_valid = 1'b0;
    #1;
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic b5,
                           input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [31:0] d1, input logic [31:0] d2,
                           input logic [31:0] imm, input logic [4:0] rd);
    in_opcode = op; in_funct3 = f3; in_funct7_b5 = b5;
    in_rs1_addr = rs1; in_rs2_addr = rs2; in_rs1_data = d1; in_rs2_data = d2;
    in_imm = imm; in_rd_addr = rd;
  endtask

  task automatic randomize_inputs();
    int sel;
    sel = $urandom_range(0, 9);
    case (sel)
      0, 1, 2, 3: in_opcode = 7'b0110011;
      4, 5, 6:    in_opcode = 7'b0010011;
      7:          in_opcode = 7'b0110111;
      8:          in_opcode = 7'b0010111;
      default:    in_opcode = 7'($urandom);
    endcase
    in_funct3    = 3'($urandom);
    in_funct7_b5 = 1'($urandom);
    in_rs1_addr  = 5'($urandom_range(0, 7));
    in_rs2_addr  = 5'($urandom_range(0, 7));
    in_rd_addr   = 5'($urandom);
    in_rs1_data  = $urandom; in_rs2_data = $urandom;
    in_imm       = $urandom; in_pc       = $urandom;
    fwd_ex_we    = 1'($urandom); fwd_ex_rd = 5'($urandom_range(0, 7)); fwd_ex_data = $urandom;
    fwd_wb_we    = 1'($urandom); fwd_wb_rd = 5'($urandom_range(0, 7)); fwd_wb_data = $urandom;
    in_valid     = ($urandom_range(0, 9) < 7);
    out_ready    = ($urandom_range(0, 3) != 0);
    flush        = ($urandom_range(0, 19) == 0);
  endtask

  // Monitor: checks the slot against the scoreboard head; pops when the next edge retires it.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("out_valid", 64'(out_valid), 64'(m_valid));
      chk("in_ready", 64'(in_ready), 64'(!m_valid || out_ready));
      chk("issue_count", 64'(issue_count), 64'(m_count));
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("slot_without_expectation", 64'(1), 64'(0));
        end else begin
          chk("alu_a", 64'(alu_a), 64'(q[0].a));
          chk("alu_b", 64'(alu_b), 64'(q[0].b));
          chk("alu_op_code", 64'(alu_op_code), 64'(q[0].op));
          chk("out_illegal", 64'(out_illegal), 64'(q[0].ill));
          chk("out_rd_addr", 64'(out_rd_addr), 64'(q[0].rd));
          if (out_ready || flush) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [31:0] c0;
    rst_n = 1'b0; flush = 0; in_valid = 0; out_ready = 0; in_pc = 0;
    fwd_ex_we = 0; fwd_ex_rd = 0; fwd_ex_data = 0;
    fwd_wb_we = 0; fwd_wb_rd = 0; fwd_wb_data = 0;
    set_instr(7'b0110011, 3'd0, 1'b0, 5'd0, 5'd0, 0, 0, 0, 5'd0);
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_alu_a", 64'(alu_a), 64'(0));
    chk("rst_alu_b", 64'(alu_b), 64'(0));
    chk("rst_op", 64'(alu_op_code), 64'hF);
    chk("rst_rd", 64'(out_rd_addr), 64'(0));
    chk("rst_illegal", 64'(out_illegal), 64'(0));
    chk("rst_count", 64'(issue_count), 64'(0));
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // ADD x3,x1,x2
    in_valid = 1; out_ready = 1;
    set_instr(7'b0110011, 3'd0, 1'b0, 5'd1, 5'd2, 32'd2, 32'd3, 0, 5'd3);
    step();
    chk("add_valid", 64'(out_valid), 64'(1));
    chk("add_a", 64'(alu_a), 64'(2));
    chk("add_b", 64'(alu_b), 64'(3));
    chk("add_op", 64'(alu_op_code), 64'(0));

    // SUB with both sources forwarded, EX over WB
    set_instr(7'b0110011, 3'd0, 1'b1, 5'd5, 5'd5, 32'd11, 32'd12, 0, 5'd6);
    fwd_ex_we = 1; fwd_ex_rd = 5; fwd_ex_data = 7;
    fwd_wb_we = 1; fwd_wb_rd = 5; fwd_wb_data = 9;
    step();
    chk("sub_a", 64'(alu_a), 64'(7));
    chk("sub_b", 64'(alu_b), 64'(7));
    chk("sub_op", 64'(alu_op_code), 64'(1));
    fwd_ex_we = 0; fwd_wb_we = 0;

    // SRAI shamt 1
    set_instr(7'b0010011, 3'b101, 1'b1, 5'd4, 5'd0, 32'h8000_0000, 0, 32'h401, 5'd7);
    step();
    chk("srai_a", 64'(alu_a), 64'h8000_0000);
    chk("srai_b", 64'(alu_b), 64'(1));
    chk("srai_op", 64'(alu_op_code), 64'(7));

    // Stall for three cycles with a new instruction waiting
    out_ready = 0;
    set_instr(7'b0110011, 3'b110, 1'b0, 5'd1, 5'd2, 32'hF0, 32'h0F, 0, 5'd8);
    c0 = m_count;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_in_ready", 64'(in_ready), 64'(0));
      chk("stall_count", 64'(issue_count), 64'(c0));
      chk("stall_op", 64'(alu_op_code), 64'(7));
    end

    // Flush on the same edge as a would-be capture
    out_ready = 1; flush = 1;
    step();
    chk("flush_valid", 64'(out_valid), 64'(0));
    chk("flush_count", 64'(issue_count), 64'(c0));
    flush = 0;

    // Unsupported opcode
    set_instr(7'b0000000, 3'd0, 1'b0, 5'd1, 5'd2, 32'h55, 32'h66, 32'h77, 5'd9);
    step();
    chk("ill_flag", 64'(out_illegal), 64'(1));
    chk("ill_op", 64'(alu_op_code), 64'hF);

    // x0 source must never be forwarded
    set_instr(7'b0110011, 3'd0, 1'b0, 5'd0, 5'd0, 32'h1234, 32'h1, 0, 5'd10);
    fwd_ex_we = 1; fwd_ex_rd = 0; fwd_ex_data = 32'hDEAD;
    step();
    chk("x0_a", 64'(alu_a), 64'h1234);
    fwd_ex_we = 0;

    // Asynchronous reset in the middle of a stall
    out_ready = 0;
    set_instr(7'b0110111, 3'd0, 1'b0, 5'd0, 5'd0, 0, 0, 32'hABCD_0000, 5'd11);
    step();
    step();
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(out_valid), 64'(0));
    chk("midrst_count", 64'(issue_count), 64'(0));
    chk("midrst_op", 64'(alu_op_code), 64'hF);
    q.delete(); m_valid = 1'b0; m_count = '0;
    @(negedge clk); #1 rst_n = 1'b1;

    for (int n = 0; n < 3000; n++) begin
      randomize_inputs();
      step();
    end
    in_valid = 0; out_ready = 1; flush = 0;
    step();
    @(negedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
